// File: rtl/spi_ram_pkg.sv
// Constants and FSM state type shared by the SPI-to-RAM writer and the
// program/data RAM wrapper.
package spi_ram_pkg;

    localparam int ADDR_W      = 15;
    localparam int DEPTH_WORDS = 20480;
    localparam int LEN_W       = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spi_word_packer.sv
// Packs received bytes little-endian into a 32-bit word and tracks which
// byte lanes have been filled since the last clear.
module spi_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_in,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        full
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  be_q,   be_d;

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        lane_d = lane_q;
        word_d = word_q;
        be_d   = be_q;
        if (clear) begin
            lane_d = '0;
            word_d = '0;
            be_d   = '0;
        end else if (byte_in) begin
            word_d[{lane_q, 3'b000} +: 8] = byte_data;
            be_d[lane_q]                  = 1'b1;
            lane_d                        = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
            be_q   <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            be_q   <= be_d;
        end
    end

    assign word = word_q;
    assign be   = be_q;
    // The byte presented now would complete the word.
    assign full = (lane_q == 2'd3);

endmodule

// File: rtl/spi_rx_ram_writer.sv
// Streams SPI receive bytes into the program/data RAM as packed 32-bit words,
// starting at a programmed word address for a programmed byte count.
module spi_rx_ram_writer
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W      = spi_ram_pkg::ADDR_W,
    parameter int DEPTH_WORDS = spi_ram_pkg::DEPTH_WORDS,
    parameter int LEN_W       = spi_ram_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len_bytes,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [LEN_W-1:0]  rem_q,     rem_d;
    logic              wrapped_q, wrapped_d;

    logic        accept;
    logic        pk_clear;
    logic        pk_full;
    logic [31:0] pk_word;
    logic [3:0]  pk_be;

    assign accept = (state_q == ST_FILL) && rx_valid;

    spi_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .byte_in   (accept),
        .byte_data (rx_data),
        .word      (pk_word),
        .be        (pk_be),
        .full      (pk_full)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wrapped_d = wrapped_q;
        pk_clear  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wrapped_d = 1'b0;
                    if (len_bytes == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_FILL;
                        addr_d   = base_addr;
                        rem_d    = len_bytes;
                        pk_clear = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
                    if (pk_full || rem_q == LEN_W'(1)) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ram_ready) begin
                    // Depth is not a power of two, so the wrap is an explicit compare.
                    if (addr_q == ADDR_W'(DEPTH_WORDS - 1)) begin
                        addr_d    = '0;
                        wrapped_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    pk_clear = 1'b1;
                    state_d  = (rem_q == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wrapped_q <= wrapped_d;
        end
    end

    // The RAM port carries zeros whenever this block does not own it.
    assign chipselect = (state_q == ST_WRITE);
    assign write      = chipselect;
    assign address    = addr_q;
    assign byteenable = chipselect ? pk_be   : 4'h0;
    assign writedata  = chipselect ? pk_word : 32'h0;
    assign rx_ready   = (state_q == ST_FILL);
    assign busy       = (state_q == ST_FILL) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign wrapped    = wrapped_q;

endmodule

// File: doc/spi_rx_ram_writer.md
# spi_rx_ram_writer

Upstream feeder for the 32-bit single-port on-chip program/data RAM. It accepts the SPI receive byte stream and packs bytes little-endian into 32-bit words. It writes those words into the RAM's slave port through chipselect/write/byteenable, starting at a programmed word address, for a programmed byte count. The CPU arms it and polls busy/done; it owns the RAM write port only while busy.

## Interface
Parameters:
- ADDR_W, 15, RAM word-address width
- DEPTH_WORDS, 20480, RAM depth in words; addresses wrap modulo this
- LEN_W, 17, byte-count width (covers DEPTH_WORDS*4)

Ports:
- clk  in  1  single clock for the block
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle arm pulse; ignored while busy
- base_addr  in  ADDR_W  first word address, sampled on start; must be < DEPTH_WORDS
- len_bytes  in  LEN_W  bytes to transfer, sampled on start
- rx_data  in  8  received SPI byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid & rx_ready
- ram_ready  in  1  RAM clock-enable qualifier (clken & ~reset_req); write completes only in a cycle where it is high
- address  out  ADDR_W  RAM word address
- byteenable  out  4  lane enables; bit i = writedata[8i+7:8i]
- chipselect  out  1  RAM select
- write  out  1  RAM write strobe (always equal to chipselect)
- writedata  out  32  packed word
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the final write has completed
- wrapped  out  1  sticky; set when the address rolled from DEPTH_WORDS-1 to 0; cleared on start

## Operation
- States are IDLE, FILL, WRITE and DONE.
- IDLE → FILL on start with len_bytes≠0. This latches base_addr into the address counter and len_bytes into the remaining counter, clears lane to 0, clears the word register and clears wrapped.
- IDLE → DONE on start with len_bytes=0. No RAM write occurs.
- FILL: rx_ready=1.
  - Each accepted byte goes to lane `lane` of the word register. Its byteenable bit is set, lane increments and remaining decrements.
  - FILL → WRITE when lane 3 is accepted, or when the last byte (remaining==1) is accepted.
- WRITE: rx_ready=0.
  - chipselect, write, address, byteenable and writedata are driven from registers.
  - The write completes in the first cycle with ram_ready=1. All outputs hold stable until then.
  - On completion, the address increments. If address was DEPTH_WORDS-1 it wraps to 0 and wrapped is set. Lane, byteenable and the word register clear.
  - Next state is DONE if remaining==0, otherwise FILL.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in FILL and WRITE.
- Unfilled lanes of a partial final word are written as 0x00 with byteenable=0.
- Arithmetic: the address counter is ADDR_W bits with explicit compare-and-wrap, not a power-of-two rollover. The remaining counter is LEN_W bits and never underflows.
- start while busy: ignored, and the latched parameters are unchanged.
- rx_valid outside FILL: no byte is consumed and no state change occurs.
- Reset mid-transfer: next cycle is IDLE with every output at its reset value. The partial word is discarded and no write is issued.

## Timing
- Reset values:
  - rx_ready=0, chipselect=0, write=0, byteenable=0
  - address=0, writedata=0
  - busy=0, done=0, wrapped=0
- start at cycle S: busy=1 and rx_ready=1 at S+1.
- Byte accepted at cycle N that fills lane 3 or is the last byte: chipselect/write=1 at N+1, rx_ready=0 at N+1.
- With ram_ready=1, the write lasts exactly one cycle and rx_ready=1 again at N+2.
- Sustained throughput is 4 bytes per 5 cycles.
- Final write completing at cycle W: done=1 and busy=0 at W+1; IDLE at W+2.
- len_bytes=0 start at S: done=1 at S+1, busy never asserts.

## Structure
- Shared package spi_ram_pkg holds:
  - ADDR_W, DEPTH_WORDS, LEN_W constants (shared with the RAM wrapper instance)
  - the state enum
- One natural sub-module, spi_word_packer, containing the lane counter, word register and byteenable accumulator. Its controls are byte-in, clear and full/last flags.
- FSM and counters stay in the top module.

## Test plan
- base_addr=0x0010, len=8, bytes 0x11..0x88 back-to-back, ram_ready=1 → writes 0x44332211 @0x0010 be=0xF, then 0x88776655 @0x0011 be=0xF; done pulse 1 cycle after the 2nd write; wrapped=0.
- base_addr=0x0000, len=6, bytes 0xA1..0xA6 → 0xA4A3A2A1 be=0xF @0x0000, then 0x0000A6A5 be=0x3 @0x0001; exactly 2 writes.
- base_addr=20479, len=8 → first write @20479, second @0; wrapped=1 after the second write; wrapped cleared by the next start.
- ram_ready=0 for 3 cycles during the first write → address/byteenable/writedata stable for 4 cycles, rx_ready=0 throughout, single completion, data correct.
- len=0 start → done at S+1, no chipselect ever. start pulsed again mid-transfer → ignored, write count unchanged.
- reset asserted after 2 bytes of a len=4 transfer → next cycle all outputs at reset values, no write issued; a fresh start then performs a normal transfer.
